// File: rtl/sipo_deser_if.sv
// Bus bundle for sipo_deser: serial input side, resync and the word handshake.
interface sipo_deser_if #(
  parameter int WIDTH = 4
) ();
  logic             sin;
  logic             sin_en;
  logic             clr;
  logic             dout_ready;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             overrun;
  logic             parity_err;

  modport master (
    output sin, sin_en, clr, dout_ready,
    input  dout, dout_valid, overrun, parity_err
  );

  modport slave (
    input  sin, sin_en, clr, dout_ready,
    output dout, dout_valid, overrun, parity_err
  );
endinterface

// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserializer with a valid/ready word register and a sticky overrun flag.
// Optional feature macro PARITY_EN: one trailing even-parity bit per word, checked into parity_err.
module sipo_deser #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic         clk,
  input logic         rst,
  sipo_deser_if.slave bus
);
  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
`ifdef PARITY_EN
    PAR   = 2'd2,
`endif
    SHIFT = 2'd1
  } state_e;

`ifdef PARITY_EN
  function automatic logic parity_of(input logic [WIDTH-1:0] data, input logic pbit);
    return (^data) ^ pbit;
  endfunction
`endif

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic [WIDTH-1:0] shift_in;
  logic             word_done;
`ifdef PARITY_EN
  logic             perr_q, perr_d;
`endif

  // Next-state: framing FSM, bit counter, shifter and output word handshake.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    dout_d    = dout_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;
    word_done = 1'b0;
`ifdef PARITY_EN
    perr_d    = perr_q;
`endif
    if (MSB_FIRST) begin
      shift_in = {shift_q[WIDTH-2:0], bus.sin};
    end else begin
      shift_in = {bus.sin, shift_q[WIDTH-1:1]};
    end

    // clr beats any bit offered in the same cycle; dout/dout_valid are left alone.
    if (bus.clr) begin
      state_d = IDLE;
      cnt_d   = '0;
      shift_d = '0;
      ovr_d   = 1'b0;
    end else if (bus.sin_en) begin
      case (state_q)
        IDLE: begin
          state_d = SHIFT;
          cnt_d   = CW'(1);
          shift_d = shift_in;
        end
        SHIFT: begin
          shift_d = shift_in;
          if (cnt_q == LAST_BIT) begin
            cnt_d = '0;
`ifdef PARITY_EN
            state_d = PAR;
`else
            state_d   = IDLE;
            word_done = 1'b1;
            dout_d    = shift_in;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`ifdef PARITY_EN
        PAR: begin
          state_d   = IDLE;
          word_done = 1'b1;
          dout_d    = shift_q;
          perr_d    = parity_of(shift_q, bus.sin);
        end
`endif
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    if (word_done) begin
      valid_d = 1'b1;
      if (valid_q && !bus.dout_ready) begin
        ovr_d = 1'b1;
      end else begin
        ovr_d = ovr_d;
      end
    end else if (bus.dout_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
`ifdef PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.overrun    = ovr_q;
`ifdef PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench for sipo_deser: two instances (MSB-first and LSB-first) share one stimulus
// stream and are compared against a queue-based reference model; PARITY_EN may be defined.
module tb_sipo_deser;
  localparam int W = 4;
`ifdef PARITY_EN
  localparam int WLEN = W + 1;
`else
  localparam int WLEN = W;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sin = 1'b0, sin_en = 1'b0, clr = 1'b0, rdy = 1'b0;

  sipo_deser_if #(.WIDTH(W)) bus_m ();
  sipo_deser_if #(.WIDTH(W)) bus_l ();

  assign bus_m.sin = sin;
  assign bus_m.sin_en = sin_en;
  assign bus_m.clr = clr;
  assign bus_m.dout_ready = rdy;
  assign bus_l.sin = sin;
  assign bus_l.sin_en = sin_en;
  assign bus_l.clr = clr;
  assign bus_l.dout_ready = rdy;

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(bus_m));
  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(bus_l));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: bits collected in arrival order, word formed when a full frame is present.
  logic         mq[$];
  logic [W-1:0] m_dout_m, m_dout_l;
  logic         m_valid, m_ovr, m_perr;

  typedef struct {
    logic s, e, c, r;
    logic [W-1:0] dm, dl;
    logic v, o, p;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_dout_m = '0;
    m_dout_l = '0;
    m_valid  = 1'b0;
    m_ovr    = 1'b0;
    m_perr   = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic e, input logic c, input logic r);
    logic done;
    done = 1'b0;
    if (c) begin
      mq.delete();
      m_ovr = 1'b0;
    end else if (e) begin
      mq.push_back(s);
      if (mq.size() == WLEN) begin
        for (int i = 0; i < W; i++) begin
          m_dout_m[W-1-i] = mq[i];
          m_dout_l[i]     = mq[i];
        end
        m_perr = 1'b0;
`ifdef PARITY_EN
        for (int i = 0; i < WLEN; i++) m_perr = m_perr ^ mq[i];
`endif
        mq.delete();
        done = 1'b1;
      end
    end
    if (done) begin
      if (m_valid && !r) m_ovr = 1'b1;
      m_valid = 1'b1;
    end else if (r) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".dout_msb"}, 32'(bus_m.dout), 32'(m_dout_m));
    chk({tag, ".dout_lsb"}, 32'(bus_l.dout), 32'(m_dout_l));
    chk({tag, ".valid_msb"}, 32'(bus_m.dout_valid), 32'(m_valid));
    chk({tag, ".valid_lsb"}, 32'(bus_l.dout_valid), 32'(m_valid));
    chk({tag, ".ovr_msb"}, 32'(bus_m.overrun), 32'(m_ovr));
    chk({tag, ".ovr_lsb"}, 32'(bus_l.overrun), 32'(m_ovr));
    chk({tag, ".perr_msb"}, 32'(bus_m.parity_err), 32'(m_perr));
    chk({tag, ".perr_lsb"}, 32'(bus_l.parity_err), 32'(m_perr));
  endtask

  task automatic cycle(input string tag, input logic s, input logic e, input logic c, input logic r);
    sin = s; sin_en = e; clr = c; rdy = r;
    @(posedge clk);
    model_step(s, e, c, r);
    #1;
    chk_all(tag);
  endtask

  // Sends data[W-1] first, with gap idle cycles before every bit but the first; appends even parity.
  task automatic send_word(input string tag, input logic [W-1:0] data, input logic r, input int gap);
    for (int i = W - 1; i >= 0; i--) begin
      if (i != W - 1) for (int g = 0; g < gap; g++) cycle(tag, 1'b0, 1'b0, 1'b0, r);
      cycle(tag, data[i], 1'b1, 1'b0, r);
    end
`ifdef PARITY_EN
    for (int g = 0; g < gap; g++) cycle(tag, 1'b0, 1'b0, 1'b0, r);
    cycle(tag, ^data, 1'b1, 1'b0, r);
`endif
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".dout_msb"}, 32'(bus_m.dout), 32'd0);
    chk({tag, ".dout_lsb"}, 32'(bus_l.dout), 32'd0);
    chk({tag, ".valid"}, 32'(bus_m.dout_valid | bus_l.dout_valid), 32'd0);
    chk({tag, ".ovr"}, 32'(bus_m.overrun | bus_l.overrun), 32'd0);
    chk({tag, ".perr"}, 32'(bus_m.parity_err | bus_l.parity_err), 32'd0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    // Table: contiguous 1,0,1,1 with ready high; valid lasts one cycle.
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0});
`ifdef PARITY_EN
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 4'b1011, 4'b1101, 1'b1, 1'b0, 1'b0});
`else
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 4'b1011, 4'b1101, 1'b1, 1'b0, 1'b0});
`endif
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 4'b1011, 4'b1101, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < tbl.size(); i++) begin
      sin = tbl[i].s; sin_en = tbl[i].e; clr = tbl[i].c; rdy = tbl[i].r;
      @(posedge clk);
      model_step(tbl[i].s, tbl[i].e, tbl[i].c, tbl[i].r);
      #1;
      chk("tbl.dout_msb", 32'(bus_m.dout), 32'(tbl[i].dm));
      chk("tbl.dout_lsb", 32'(bus_l.dout), 32'(tbl[i].dl));
      chk("tbl.valid", 32'(bus_m.dout_valid), 32'(tbl[i].v));
      chk("tbl.ovr", 32'(bus_m.overrun), 32'(tbl[i].o));
      chk("tbl.perr", 32'(bus_m.parity_err), 32'(tbl[i].p));
    end

    // Gapped stream: 0,1,1,0 with 3 idle cycles between bits.
    send_word("gap", 4'b0110, 1'b1, 3);
    chk("gap.dout_lsb", 32'(bus_l.dout), 32'(4'b0110));
    chk("gap.valid", 32'(bus_l.dout_valid), 32'd1);
    cycle("gap", 1'b0, 1'b0, 1'b0, 1'b1);

    // Backpressure: two words unconsumed, overrun sticks until clr.
    send_word("bp", 4'b1011, 1'b0, 0);
    send_word("bp", 4'b0110, 1'b0, 0);
    chk("bp.dout_msb", 32'(bus_m.dout), 32'(4'b0110));
    chk("bp.valid", 32'(bus_m.dout_valid), 32'd1);
    chk("bp.ovr", 32'(bus_m.overrun), 32'd1);
    repeat (3) cycle("bp", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("bp.ovr_hold", 32'(bus_m.overrun), 32'd1);
    cycle("bp", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("bp.ovr_clr", 32'(bus_m.overrun), 32'd0);
    chk("bp.valid_kept", 32'(bus_m.dout_valid), 32'd1);
    cycle("bp", 1'b0, 1'b0, 1'b0, 1'b1);

    // Resync: two bits, clr with a bit offered, then a full word.
    cycle("rsy", 1'b1, 1'b1, 1'b0, 1'b1);
    cycle("rsy", 1'b1, 1'b1, 1'b0, 1'b1);
    cycle("rsy", 1'b1, 1'b1, 1'b1, 1'b1);
    send_word("rsy", 4'b1100, 1'b1, 0);
    chk("rsy.dout_msb", 32'(bus_m.dout), 32'(4'b1100));
    chk("rsy.valid", 32'(bus_m.dout_valid), 32'd1);

`ifdef PARITY_EN
    // Wrong parity bit flags parity_err while the data still lands.
    for (int i = 3; i >= 0; i--) cycle("par", i != 2, 1'b1, 1'b0, 1'b1);
    cycle("par", 1'b0, 1'b1, 1'b0, 1'b1);
    chk("par.perr", 32'(bus_m.parity_err), 32'd1);
    chk("par.dout_msb", 32'(bus_m.dout), 32'(4'b1011));
    chk("par.valid", 32'(bus_m.dout_valid), 32'd1);
`endif

    // Async reset mid-word with a pending overrun, then a clean word.
    send_word("rst", 4'b0110, 1'b0, 0);
    send_word("rst", 4'b1011, 1'b0, 0);
    cycle("rst", 1'b1, 1'b1, 1'b0, 1'b0);
    cycle("rst", 1'b0, 1'b1, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1 chk_zero("rst_async");
    model_reset();
    #1 rst = 1'b0;
    send_word("rst", 4'b1011, 1'b1, 0);
    chk("rst.dout_msb", 32'(bus_m.dout), 32'(4'b1011));

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      cycle("rnd", 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 31) == 0, $urandom_range(0, 2) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sipo_deser.md
SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 Parameter WIDTH, default 4: word width in bits, legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 means the first received bit is dout[WIDTH-1]; 0 means the first received bit is dout[0].
REQ-003 clk  input  1: single clock; all state changes on its rising edge.
REQ-004 rst  input  1: asynchronous, active-high reset.
REQ-005 sin  input  1: serial data bit, sampled only when sin_en=1.
REQ-006 sin_en  input  1: bit-valid strobe; one bit is consumed per clock with sin_en=1.
REQ-007 clr  input  1: synchronous framing resync; discards any partial word.
REQ-008 dout  output  WIDTH: last completed word.
REQ-009 dout_valid  output  1: dout holds an unconsumed word.
REQ-010 dout_ready  input  1: consumer accepts dout when dout_ready=1 and dout_valid=1 at a rising edge.
REQ-011 overrun  output  1: sticky flag; a completed word overwrote an unconsumed word.
REQ-012 parity_err  output  1: parity status of dout, qualified by dout_valid.

Function
REQ-013 State machine states: IDLE (bit count 0), SHIFT (1..WIDTH-1 bits held) and, only when PARITY_EN is defined, PAR (waiting for the parity bit).
- IDLE->SHIFT on sin_en.
- SHIFT->IDLE on the WIDTH-th bit when PARITY_EN is undefined.
- SHIFT->PAR on the WIDTH-th bit when PARITY_EN is defined.
- PAR->IDLE on the parity bit.
REQ-014 A 0..WIDTH-1 bit counter advances only on sin_en=1 and wraps to 0 at word completion; cycles with sin_en=0 hold all state (gaps allowed).
REQ-015 Bit placement: MSB_FIRST=1 shifts left, with sin entering bit 0; MSB_FIRST=0 shifts right, with sin entering bit WIDTH-1.
REQ-016 Word completion is the edge that samples the final bit: the WIDTH-th data bit, or the parity bit when PARITY_EN is defined. At that edge, dout is loaded and dout_valid is set to 1, so both are visible in the following cycle (zero added latency).
REQ-017 dout_valid clears at an edge with dout_ready=1 unless a word completes at the same edge; in that case dout is reloaded and dout_valid stays 1, with no overrun.
REQ-018 Word completion with dout_valid=1 and dout_ready=0: the new word replaces dout, dout_valid stays 1, and overrun is set to 1.
REQ-019 overrun stays 1 until rst or clr.
REQ-020 clr=1: the counter returns to 0, the state returns to IDLE, the partial word is discarded, and overrun clears. Any sin_en bit in the same cycle is discarded (clr wins). dout and dout_valid are unaffected.
REQ-021 dout is stable whenever dout_valid=1 and no completion occurs.

Reset
REQ-022 rst=1 forces the following immediately, regardless of clk, including mid-word:
- state IDLE, counter 0, shift register 0
- dout=0, dout_valid=0, overrun=0, parity_err=0
REQ-023 The first rising edge after rst deasserts is a normal operating edge.

Configuration
REQ-024 Macro PARITY_EN. When defined:
- each word is followed by one parity bit;
- even parity applies, i.e. the XOR of the WIDTH data bits and the parity bit is 0;
- parity_err is loaded with that XOR at word completion.
REQ-025 When PARITY_EN is undefined, the PAR state is absent, words are WIDTH bits long, and parity_err is tied to 0. The port list is identical in both builds.

Verification
REQ-026 Reset: assert rst after 2 of 4 bits, then send 1,0,1,1 -> dout=4'b1011 after the 4th bit; the earlier bits are lost; all outputs read 0 during rst.
REQ-027 Contiguous stream, WIDTH=4, MSB_FIRST=1, dout_ready=1: bits 1,0,1,1 -> dout=4'b1011 with dout_valid=1 for exactly one cycle.
REQ-028 Gapped stream: bits 0,1,1,0 with 3 idle cycles between bits, MSB_FIRST=0 -> dout=4'b0110; dout_valid rises only after the 4th bit.
REQ-029 Backpressure: dout_ready=0, words 1011 then 0110 -> dout=4'b0110, dout_valid=1, overrun=1; overrun holds until clr.
REQ-030 Resync: send 1,1, then clr, then 1,1,0,0 -> dout=4'b1100; no word is produced from the first two bits; clr together with sin_en discards that bit.
REQ-031 PARITY_EN: data 1011 with parity bit 1 -> parity_err=0; data 1011 with parity bit 0 -> parity_err=1; dout=4'b1011 in both cases, with dout_valid set on the parity-bit edge.
